beep_gen: RTL and testbench

BEEP_GEN -- requirements
Module: beep_gen

---
 rtl/clock_pkg.sv | 36 +++
 rtl/beep_gen_if.sv | 30 +++
 rtl/beep_gen_tick_gen.sv | 31 +++
 rtl/beep_gen.sv | 167 ++++++++++++++++
 tb/tb_beep_gen.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timing for the beep sequencer.
// State encoding, output bundle and counter-width helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  typedef struct packed {
    logic beep;
    logic tone;
    logic busy;
    logic done;
  } outs_t;

  localparam int DEF_TICK_DIV  = 250000;
  localparam int DEF_ON_TICKS  = 1;
  localparam int DEF_OFF_TICKS = 1;
  localparam int DEF_BEEPS     = 3;
  localparam int DEF_TONE_DIV  = 500;

  // Width to hold 0..n-1, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int imax(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beep_gen_if.sv
// Control/status bundle between the beep sequencer and its user.
// master drives trig/cancel; slave is the sequencer.
interface beep_gen_if;

  logic trig;
  logic cancel;
  logic beep_out;
  logic tone_out;
  logic busy;
  logic done;

  modport master (
    output trig,
    output cancel,
    input  beep_out,
    input  tone_out,
    input  busy,
    input  done
  );

  modport slave (
    input  trig,
    input  cancel,
    output beep_out,
    output tone_out,
    output busy,
    output done
  );

endinterface

// File: rtl/beep_gen_tick_gen.sv
// Time-base divider: one-cycle tick every TICK_DIV clocks.
// restart zeroes the divider so a phase never starts mid-tick.
module tick_gen
  import clock_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_in,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int W = cw(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/beep_gen.sv
// Beep sequencer: BEEPS tone bursts separated by gaps.
// Retrigger restarts, cancel aborts, done marks clean finish.
module beep_gen
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int BEEPS     = DEF_BEEPS,
  parameter int TONE_DIV  = DEF_TONE_DIV
) (
  input logic       clk_in,
  input logic       clr_n,
  beep_gen_if.slave bus
);

  localparam int PW = cw(imax(ON_TICKS, OFF_TICKS));
  localparam int BW = cw(BEEPS + 1);
  localparam int TW = cw(TONE_DIV);

  localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
  localparam logic [BW-1:0] N_BEEPS   = BW'(BEEPS);
  localparam logic [BW-1:0] ONE_BEEP  = BW'(1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  state_t        state;
  state_t        state_d;
  outs_t         q;
  outs_t         d;
  logic [PW-1:0] ph_cnt;
  logic [PW-1:0] ph_cnt_d;
  logic [BW-1:0] beep_cnt;
  logic [BW-1:0] beep_cnt_d;
  logic [TW-1:0] tone_cnt;
  logic [TW-1:0] tone_cnt_d;

  logic tick;
  logic restart;
  logic phase_end;
  logic kill;
  logic go;
  logic on_end;
  logic off_end;
  logic last;
  logic start;
  logic advance;
  logic finish;
  logic enter;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_in  (clk_in),
    .clr_n   (clr_n),
    .restart (restart),
    .tick    (tick)
  );

  assign restart = enter || (state == ST_IDLE);

  assign phase_end = tick &&
    (ph_cnt == ((state == ST_ON) ? ON_LAST : OFF_LAST));

  // cancel outranks trig, trig outranks phase expiry
  assign kill    = bus.cancel;
  assign go      = bus.trig && !bus.cancel;
  assign on_end  = !bus.cancel && !bus.trig &&
                   phase_end && (state == ST_ON);
  assign off_end = !bus.cancel && !bus.trig &&
                   phase_end && (state == ST_OFF);
  assign last    = (beep_cnt >= N_BEEPS);

  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      q        <= '0;
      ph_cnt   <= '0;
      beep_cnt <= '0;
      tone_cnt <= '0;
    end else begin
      state    <= state_d;
      q        <= d;
      ph_cnt   <= ph_cnt_d;
      beep_cnt <= beep_cnt_d;
      tone_cnt <= tone_cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (1'b1)
      kill: begin
        state_d = ST_IDLE;
      end
      go: begin
        state_d = ST_ON;
        start   = 1'b1;
      end
      on_end: begin
        if (last) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      off_end: begin
        state_d = ST_ON;
        advance = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign enter = start || (state_d != state);

  always_comb begin
    d          = '0;
    ph_cnt_d   = ph_cnt;
    beep_cnt_d = beep_cnt;
    tone_cnt_d = '0;

    d.busy = (state_d != ST_IDLE);
    d.beep = (state_d == ST_ON);
    d.done = finish;

    if (state_d == ST_IDLE) begin
      beep_cnt_d = '0;
    end else if (start) begin
      beep_cnt_d = ONE_BEEP;
    end else if (advance && !last) begin
      beep_cnt_d = beep_cnt + 1'b1;
    end

    if (enter || state_d == ST_IDLE) begin
      ph_cnt_d = '0;
    end else if (tick) begin
      ph_cnt_d = ph_cnt + 1'b1;
    end

    // tone phase is anchored to each ON entry
    if (!d.beep) begin
      d.tone     = 1'b0;
      tone_cnt_d = '0;
    end else if (enter) begin
      d.tone     = 1'b1;
      tone_cnt_d = '0;
    end else if (tone_cnt == TONE_LAST) begin
      d.tone     = !q.tone;
      tone_cnt_d = '0;
    end else begin
      d.tone     = q.tone;
      tone_cnt_d = tone_cnt + 1'b1;
    end
  end

  assign bus.beep_out = q.beep;
  assign bus.tone_out = q.tone;
  assign bus.busy     = q.busy;
  assign bus.done     = q.done;

endmodule

// File: tb/tb_beep_gen.sv
// Self-checking bench for beep_gen: vector table,
// directed corner sequences and a random run vs. a timeline model.
module tb_beep_gen;
  import clock_pkg::*;

  localparam int TD    = 4;
  localparam int ONT   = 2;
  localparam int OFFT  = 1;
  localparam int NB    = 3;
  localparam int TND   = 2;
  localparam int ONL   = ONT * TD;
  localparam int OFFL  = OFFT * TD;
  localparam int PER   = ONL + OFFL;
  localparam int TOTAL = NB * ONL + (NB - 1) * OFFL;

  logic clk_in = 1'b0;
  logic clr_n  = 1'b1;

  beep_gen_if bus ();

  beep_gen #(
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT),
    .BEEPS     (NB),
    .TONE_DIV  (TND)
  ) dut (
    .clk_in (clk_in),
    .clr_n  (clr_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         reps;
    bit         trig;
    bit         cancel;
    logic [3:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cn     = 0;

  // timeline model: sequence age k since the start edge
  bit m_act  = 1'b0;
  bit m_done = 1'b0;
  int m_k    = 0;

  function automatic logic [3:0] model_out();
    logic b;
    logic t;
    b = m_act && ((m_k % PER) < ONL);
    t = b && ((((m_k % PER) / TND) % 2) == 0);
    return {b, t, m_act, m_done};
  endfunction

  function automatic logic [3:0] dut_out();
    return {bus.beep_out, bus.tone_out, bus.busy, bus.done};
  endfunction

  task automatic check(
    input string      name,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b",
               name, cn, act, exp);
    end
  endtask

  task automatic check_int(
    input string name,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(
    input bit t,
    input bit c,
    input bit r
  );
    m_done = 1'b0;
    if (!r) begin
      m_act = 1'b0;
    end else if (c) begin
      m_act = 1'b0;
    end else if (t) begin
      m_act = 1'b1;
      m_k   = 0;
    end else if (m_act) begin
      m_k++;
      if (m_k == TOTAL) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cyc(
    input bit t,
    input bit c
  );
    bus.trig   = t;
    bus.cancel = c;
    @(posedge clk_in);
    model_edge(t, c, clr_n);
    cn++;
    #1;
    check("model", dut_out(), model_out());
  endtask

  vec_t tbl[17];

  int dones;
  int done_at;
  int rises;
  int seen;
  bit prev_b;
  bit rt;
  bit rc;

  initial begin
    // {beep, tone, busy, done} expected in the cycle after the inputs
    tbl = '{
      '{1, 1'b1, 1'b0, 4'b1110},
      '{1, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{2, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{4, 1'b0, 1'b0, 4'b0010},
      '{2, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{2, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{4, 1'b0, 1'b0, 4'b0010},
      '{2, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{2, 1'b0, 1'b0, 4'b1110},
      '{2, 1'b0, 1'b0, 4'b1010},
      '{1, 1'b0, 1'b0, 4'b0001},
      '{3, 1'b0, 1'b0, 4'b0000}
    };

    bus.trig   = 1'b0;
    bus.cancel = 1'b0;
    #1 clr_n = 1'b0;
    #1 check("reset", dut_out(), 4'b0000);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    clr_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);

    // normal three-beep run
    cn = 0;
    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        cyc(tbl[i].trig, tbl[i].cancel);
        check("table", dut_out(), tbl[i].exp);
      end
    end

    // retrigger during the first gap
    cn = 0;
    cyc(1'b1, 1'b0);
    while (cn < 10) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("retrig_on", dut_out(), 4'b1110);
    dones   = 0;
    done_at = -1;
    rises   = 1;
    prev_b  = 1'b1;
    while (cn < 46) begin
      cyc(1'b0, 1'b0);
      if (bus.done === 1'b1) begin
        dones++;
        done_at = cn;
      end
      if (bus.beep_out === 1'b1 && !prev_b) rises++;
      prev_b = (bus.beep_out === 1'b1);
    end
    check_int("retrig_dones", dones, 1);
    check_int("retrig_done_cycle", done_at, 43);
    check_int("retrig_beeps", rises, 3);

    // cancel mid-beep, then a fresh start
    cn = 0;
    cyc(1'b1, 1'b0);
    while (cn < 5) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("cancel_zero", dut_out(), 4'b0000);
    dones = 0;
    while (cn < 20) begin
      cyc(1'b0, 1'b0);
      if (bus.done === 1'b1) dones++;
    end
    check_int("cancel_no_done", dones, 0);
    cyc(1'b1, 1'b0);
    check("cancel_restart", dut_out(), 4'b1110);
    repeat (40) cyc(1'b0, 1'b0);

    // trig and cancel together
    cn = 0;
    cyc(1'b1, 1'b1);
    seen = 0;
    repeat (12) begin
      if (bus.busy !== 1'b0 || bus.beep_out !== 1'b0) seen++;
      cyc(1'b0, 1'b0);
    end
    check_int("trig_cancel_idle", seen, 0);

    // asynchronous reset mid-sequence
    cn = 0;
    cyc(1'b1, 1'b0);
    while (cn < 15) cyc(1'b0, 1'b0);
    #2 clr_n = 1'b0;
    m_act  = 1'b0;
    m_done = 1'b0;
    #1 check("async_reset", dut_out(), 4'b0000);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    #2 clr_n = 1'b1;
    seen = 0;
    repeat (40) begin
      cyc(1'b0, 1'b0);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
    end
    check_int("reset_stays_idle", seen, 0);
    cyc(1'b1, 1'b0);
    check("reset_restart", dut_out(), 4'b1110);

    // random trig/cancel traffic
    repeat (800) begin
      rt = ($urandom_range(0, 39) == 0);
      rc = ($urandom_range(0, 99) == 0);
      cyc(rt, rc);
    end
    repeat (40) cyc(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
